// File: rtl/sc_ctrl_pkg.sv
// Shared definitions for the switched-capacitor phase generator: state
// encoding, default widths and the zero-to-one clamp used on config values.
package sc_ctrl_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int CYC_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PH1   = 3'd1,
    GAP12 = 3'd2,
    PH2   = 3'd3,
    GAP21 = 3'd4
  } phase_state_t;

  // A programmed length of zero would stall the counter, so it means one cycle.
  function automatic logic [31:0] clamp_to_one(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/sc_down_counter.sv
// Loadable down-counter shared by all timed states. It holds "cycles left
// minus one", so the zero flag marks the last cycle of the current state.
// next_zero lets the owner register outputs that must line up with that
// last cycle.
module sc_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             next_zero
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Load wins; otherwise count down and stick at zero.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (count != '0) begin
      count_next = count - 1'b1;
    end
  end

  assign zero      = (count == '0);
  assign next_zero = (count_next == '0);

  // Counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/sc_phase_gen.sv
// Non-overlapping two-phase clock generator for the switched-capacitor
// filter. phi1 (sample) and phi2 (transfer) are separated by programmable
// dead time; both are registered copies of the next-state decode so they
// are glitch-free and can never be high together.
module sc_phase_gen
  import sc_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] phase_len,
  input  logic [CNT_W-1:0] dead_len,
  output logic             phi1,
  output logic             phi2,
  output logic             busy,
  output logic             cycle_done,
  output logic [CYC_W-1:0] cycle_cnt
);

  phase_state_t     state;
  phase_state_t     next_state;
  logic [CNT_W-1:0] phase_sh;
  logic [CNT_W-1:0] dead_sh;
  logic [CNT_W-1:0] phase_new;
  logic [CNT_W-1:0] dead_new;
  logic             stop_q;
  logic             stopping;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             cnt_next_zero;
  logic             enter_ph1;
  logic             done_next;

  // Clamped versions of the live config, captured at period boundaries.
  assign phase_new = CNT_W'(clamp_to_one(32'(phase_len)));
  assign dead_new  = CNT_W'(clamp_to_one(32'(dead_len)));

  // Once en has been seen low the run is winding down; a late re-assert
  // must not revive it until the FSM has passed through IDLE.
  assign stopping  = stop_q | ~en;
  assign enter_ph1 = (next_state == PH1) && (state != PH1);

  sc_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .zero      (cnt_zero),
    .next_zero (cnt_next_zero)
  );

  // Next-state decode; phases end early on en low, gaps always run out.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (en) next_state = PH1;
      PH1:     if (cnt_zero || !en) next_state = GAP12;
      GAP12:   if (cnt_zero) next_state = stopping ? IDLE : PH2;
      PH2:     if (cnt_zero || !en) next_state = GAP21;
      GAP21:   if (cnt_zero) next_state = stopping ? IDLE : PH1;
      default: next_state = IDLE;
    endcase
  end

  // Reload the shared counter on every state change with the new state's
  // length minus one; PH1 uses the freshly latched phase length.
  always_comb begin
    cnt_load     = (next_state != state) && (next_state != IDLE);
    cnt_load_val = dead_sh - 1'b1;
    if (enter_ph1) begin
      cnt_load_val = phase_new - 1'b1;
    end else if (next_state == PH2) begin
      cnt_load_val = phase_sh - 1'b1;
    end
  end

  // The period completes in the last GAP21 cycle, whether or not it restarts.
  assign done_next = (next_state == GAP21) && cnt_next_zero;

  // State, shadow config, wind-down flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase_sh   <= '0;
      dead_sh    <= '0;
      stop_q     <= 1'b0;
      phi1       <= 1'b0;
      phi2       <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state <= next_state;
      if (enter_ph1) begin
        phase_sh <= phase_new;
        dead_sh  <= dead_new;
      end
      if (next_state == IDLE) begin
        stop_q <= 1'b0;
      end else if (!en) begin
        stop_q <= 1'b1;
      end
      phi1       <= (next_state == PH1);
      phi2       <= (next_state == PH2);
      busy       <= (next_state != IDLE);
      cycle_done <= done_next;
      if (done_next) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sc_phase_gen.sv
// Directed self-checking bench for sc_phase_gen: vector tables for the basic
// and clamped periods, hand sequences for disable, config change and async
// reset, and a randomized run watching the non-overlap invariant.
module tb_sc_phase_gen;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  phase_len;
  logic [7:0]  dead_len;
  logic        phi1;
  logic        phi2;
  logic        busy;
  logic        cycle_done;
  logic [15:0] cycle_cnt;

  int compared;
  int mismatched;

  typedef struct {
    bit          rst;
    logic        en;
    logic [7:0]  pl;
    logic [7:0]  dl;
    logic        e_phi1;
    logic        e_phi2;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  sc_phase_gen #(.CNT_W(8), .CYC_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .phase_len  (phase_len),
    .dead_len   (dead_len),
    .phi1       (phi1),
    .phi2       (phi2),
    .busy       (busy),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, logic e, logic [7:0] p, logic [7:0] d,
                              logic x1, logic x2, logic b, logic dn,
                              logic [15:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.pl = p; v.dl = d;
    v.e_phi1 = x1; v.e_phi2 = x2; v.e_busy = b; v.e_done = dn; v.e_cnt = c;
    return v;
  endfunction

  // Compare one value and log a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic x1, input logic x2,
                          input logic b, input logic dn, input logic [15:0] c);
    checkOutput({tag, ".phi1"}, 32'(phi1), 32'(x1));
    checkOutput({tag, ".phi2"}, 32'(phi2), 32'(x2));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
    checkOutput({tag, ".done"}, 32'(cycle_done), 32'(dn));
    checkOutput({tag, ".cnt"}, 32'(cycle_cnt), 32'(c));
  endtask

  // Reset with en low; returns at a falling edge with the DUT idle.
  task automatic doReset();
    en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one vector's inputs, let one rising edge pass, then compare.
  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.rst) doReset();
    en = v.en;
    phase_len = v.pl;
    dead_len = v.dl;
    @(negedge clk);
    checkAll($sformatf("vec%0d", idx), v.e_phi1, v.e_phi2, v.e_busy, v.e_done, v.e_cnt);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    en = 1'b0;
    phase_len = 8'd0;
    dead_len = 8'd0;
    rst_n = 1'b0;

    // P=3, D=2: period of 10, then en drops during the second PH1 cycle.
    vecs.push_back(mk(1, 1, 3, 2, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 3, 2, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 2, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3, 2, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3, 2, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 3, 2, 0, 0, 0, 0, 1));
    // P=0, D=0 clamp to 1: period of 4.
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 2));

    // Reset and idle for 20 cycles with en low.
    doReset();
    for (int i = 0; i < 20; i++) begin
      checkAll("idle", 0, 0, 0, 0, 0);
      @(negedge clk);
    end

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Mid-phase disable, P=5 D=2, with en re-asserted during the gap.
    doReset();
    phase_len = 8'd5;
    dead_len = 8'd2;
    en = 1'b1;
    @(negedge clk);
    checkAll("dis.c1", 1, 0, 1, 0, 0);
    @(negedge clk);
    checkAll("dis.c2", 1, 0, 1, 0, 0);
    en = 1'b0;
    @(negedge clk);
    checkAll("dis.c3", 0, 0, 1, 0, 0);
    en = 1'b1;
    @(negedge clk);
    checkAll("dis.c4", 0, 0, 1, 0, 0);
    @(negedge clk);
    checkAll("dis.c5", 0, 0, 0, 0, 0);
    @(negedge clk);
    checkAll("dis.c6", 1, 0, 1, 0, 0);

    // Config change during PH2: P=4 D=1, then P=2 from cycle 6.
    doReset();
    phase_len = 8'd4;
    dead_len = 8'd1;
    en = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 6) phase_len = 8'd2;
      if (c <= 4) checkAll($sformatf("cfg.c%0d", c), 1, 0, 1, 0, 0);
      else if (c == 5) checkAll("cfg.c5", 0, 0, 1, 0, 0);
      else if (c <= 9) checkAll($sformatf("cfg.c%0d", c), 0, 1, 1, 0, 0);
      else if (c == 10) checkAll("cfg.c10", 0, 0, 1, 1, 1);
      else if (c <= 12) checkAll($sformatf("cfg.c%0d", c), 1, 0, 1, 0, 1);
      else checkAll("cfg.c13", 0, 0, 1, 0, 1);
    end

    // Async reset during PH2 with P=6, D=1 after one full period.
    doReset();
    phase_len = 8'd6;
    dead_len = 8'd1;
    en = 1'b1;
    repeat (14) @(negedge clk);
    checkAll("ar.done", 0, 0, 1, 1, 1);
    repeat (9) @(negedge clk);
    checkAll("ar.ph2", 0, 1, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("ar.phi2_async", 32'(phi2), 32'd0);
    checkOutput("ar.busy_async", 32'(busy), 32'd0);
    checkOutput("ar.cnt_async", 32'(cycle_cnt), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkAll("ar.after", 0, 0, 0, 0, 0);

    // Randomized run: phases never overlap and never touch back to back.
    doReset();
    begin
      logic prev1;
      logic prev2;
      prev1 = 1'b0;
      prev2 = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        en = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 7) == 0) begin
          phase_len = 8'($urandom_range(0, 4));
          dead_len = 8'($urandom_range(0, 3));
        end
        @(negedge clk);
        checkOutput("rnd.overlap", 32'(phi1 & phi2), 32'd0);
        checkOutput("rnd.adjacent", 32'((prev1 & phi2) | (prev2 & phi1)), 32'd0);
        prev1 = phi1;
        prev2 = phi2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
